bus_term_fifo: RTL
==================

// Module: bus_term_fifo
// PURPOSE
//   Per-terminal interface between a test agent/host and bs_gnrtr_n_rbtr.
//   TX FIFO: buffers host packets; presents head on D_pop/pndng; dequeues on bus pop.
//   RX FIFO: captures bus push/D_push deliveries, filters by destination ID, queues for host.
//   One instance per terminal; the bus array's pndng/D_pop/push/D_push slices attach here.
// PARAMETERS
//   pckg_sz    32     packet width in bits; bits [pckg_sz-1 -: 8] are the destination ID
//   depth      16     entries per FIFO (TX and RX); power of two, >= 2
//   term_id    0      8-bit ID of this terminal
//   broadcast  8'hFF  destination ID accepted by every terminal
// PORTS
//   clk        in   1                  clock, all logic on posedge
//   reset      in   1                  synchronous, active-high
//   tx_wr      in   1                  host write strobe into TX FIFO
//   tx_data    in   pckg_sz            host packet
//   tx_full    out  1                  TX FIFO holds depth entries
//   tx_count   out  $clog2(depth+1)    TX occupancy
//   tx_ovf     out  1                  sticky: host write dropped while full
//   pndng      out  1                  TX FIFO non-empty (to bus)
//   D_pop      out  pckg_sz            TX head packet (to bus)
//   pop        in   1                  bus dequeue strobe
//   push       in   1                  bus delivery strobe
//   D_push     in   pckg_sz            delivered packet
//   rx_valid   out  1                  RX FIFO non-empty
//   rx_data    out  pckg_sz            RX head packet
//   rx_rd      in   1                  host dequeue strobe
//   rx_ovf     out  1                  sticky: delivery dropped, RX full
//   id_err     out  1                  sticky: delivery dropped, ID mismatch
// BEHAVIOUR
//   Reset (sync, reset=1 at posedge): pointers/counts 0, all sticky flags 0.
//     pndng=0, rx_valid=0, tx_full=0, tx_count=0.
//     Reset mid-operation discards all queued packets; it takes priority over same-cycle strobes.
//   Both FIFOs are first-word fall-through.
//     D_pop = TX head, rx_data = RX head; both are combinational from the memory read port.
//     D_pop and rx_data drive 0 when their FIFO is empty.
//   Write latency: a packet written at edge N is visible on D_pop/pndng after edge N (0-cycle FWFT).
//   TX at posedge:
//     - tx_wr & !full: store, wptr++ (mod depth).
//     - tx_wr & full & !pop: drop; tx_ovf<=1.
//     - tx_wr & full & pop: dequeue and store both occur; count unchanged, no overflow.
//     - pop & empty: ignored, no underflow flag (bus only pops when pndng=1).
//     - pop & tx_wr & empty: write only.
//   RX accept condition: push & (D_push[pckg_sz-1 -: 8]==term_id | ==broadcast).
//     - push with ID mismatch: drop; id_err<=1 (even if RX full).
//     - accepted & RX full & !rx_rd: drop; rx_ovf<=1.
//     - accepted & full & rx_rd: dequeue and store both occur.
//     - rx_rd & empty: ignored.
//   Pointers: log2(depth)-bit, natural wrap.
//     Count: $clog2(depth+1)-bit up/down counter; full = (count==depth).
//   Sticky flags clear only on reset.
//   No packet is reordered, duplicated or altered; each FIFO is strict FIFO order.
// TESTING
//   1. Reset, write 0xAA000001, 0xAA000002 -> pndng=1 next cycle, D_pop=0xAA000001, tx_count=2;
//      pop -> D_pop=0xAA000002; pop -> pndng=0, D_pop=0.
//   2. Write 17 pkts, depth=16, no pop -> tx_full=1, tx_count=16, tx_ovf=1, 17th absent;
//      then tx_wr+pop while full -> count stays 16, tx_ovf unchanged.
//   3. term_id=3: push 0x03001234, 0xFF00ABCD, 0x05000000 -> rx_data 0x03001234 then 0xFF00ABCD;
//      third packet dropped, id_err=1.
//   4. Fill RX with 16 matching pkts, push 17th -> rx_ovf=1;
//      push+rx_rd same cycle when full -> accepted, order preserved.
//   5. Wrap: 40 interleaved write/pop pairs with incrementing data -> D_pop sequence monotone,
//      no loss across pointer wrap.
//   6. Reset asserted with 5 queued and tx_wr=1 -> next cycle pndng=0, tx_count=0, flags 0.

Source files
------------

// File: rtl/bus_term_fifo.sv
// Per-terminal bus interface: TX FIFO feeding the bus arbiter and an ID-filtered RX FIFO for the host.
// Both queues are first-word fall-through with zero-latency visibility of a freshly written head.

module bus_term_fifo_buf #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       rd_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full;
  logic          do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A read frees the slot in the same cycle, so a write while full is taken when paired with a read.
  always_comb begin
    do_rd   = rd_i & ~empty;
    do_wr   = wr_i & (~full | rd_i);
    drop_o  = wr_i & full & ~rd_i;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_wr) wptr_d = wptr_q + AW'(1);
    if (do_rd) rptr_d = rptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

module bus_term_fifo #(
  parameter int         pckg_sz   = 32,
  parameter int         depth     = 16,
  parameter logic [7:0] term_id   = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_wr,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_full,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic                       tx_ovf,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  output logic                       rx_valid,
  output logic [pckg_sz-1:0]         rx_data,
  input  logic                       rx_rd,
  output logic                       rx_ovf,
  output logic                       id_err
);

  localparam int CW = $clog2(depth+1);

  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_drop, rx_drop;
  logic [7:0]    rx_id;
  logic          rx_accept, rx_reject;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          id_err_q, id_err_d;

  bus_term_fifo_buf #(
    .W     (pckg_sz),
    .DEPTH (depth)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (tx_wr),
    .wdata_i (tx_data),
    .rd_i    (pop),
    .rdata_o (D_pop),
    .count_o (tx_cnt),
    .drop_o  (tx_drop)
  );

  assign rx_id     = D_push[pckg_sz-1 -: 8];
  assign rx_accept = push & ((rx_id == term_id) | (rx_id == broadcast));
  assign rx_reject = push & ~rx_accept;

  bus_term_fifo_buf #(
    .W     (pckg_sz),
    .DEPTH (depth)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .wr_i    (rx_accept),
    .wdata_i (D_push),
    .rd_i    (rx_rd),
    .rdata_o (rx_data),
    .count_o (rx_cnt),
    .drop_o  (rx_drop)
  );

  always_comb begin
    tx_ovf_d = tx_ovf_q | tx_drop;
    rx_ovf_d = rx_ovf_q | rx_drop;
    id_err_d = id_err_q | rx_reject;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      id_err_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      id_err_q <= id_err_d;
    end
  end

  assign tx_count = tx_cnt;
  assign tx_full  = (tx_cnt == CW'(depth));
  assign pndng    = (tx_cnt != '0);
  assign rx_valid = (rx_cnt != '0);
  assign tx_ovf   = tx_ovf_q;
  assign rx_ovf   = rx_ovf_q;
  assign id_err   = id_err_q;

endmodule
